// File: rtl/router_pkg.sv
// Shared router types: scheduler FSM states, grant vectors and channel ids.
package router_pkg;

  localparam int NUM_CH = 4;

  typedef enum logic [1:0] {IDLE, SEND, RTZ} sched_state_t;
  typedef logic [3:0] grant_t;
  typedef logic [1:0] chan_id_t;

  // One-hot grant vector for a channel id.
  function automatic grant_t to_onehot(chan_id_t id);
    return grant_t'(1) << id;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Round-robin picker: first requester after last_win, searched last_win+1 .. last_win+4 (mod 4).
module rr_pick4
  import router_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  chan_id_t          last_win,
  output logic              found,
  output chan_id_t          win
);

  // Scan farthest-to-nearest so the nearest requester after last_win is the last one written.
  always_comb begin
    // NOTE: every output gets a default before the loop, so no path leaves a latch behind.
    found = 1'b0;
    win   = last_win;
    for (int k = NUM_CH; k >= 1; k--) begin
      if (req[last_win + chan_id_t'(k)]) begin
        found = 1'b1;
        win   = last_win + chan_id_t'(k);
      end
    end
  end

endmodule

// File: rtl/flit_scheduler4.sv
// 4:1 flit scheduler: round-robin with packet locking, 4-phase req/ack on every channel.
module flit_scheduler4
  import router_pkg::*;
#(
  parameter int data_width = 32,
  parameter int TAIL_BIT   = 31
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inA_req,
  input  logic [data_width-1:0] inA_data,
  output logic                  inA_ack,
  input  logic                  inB_req,
  input  logic [data_width-1:0] inB_data,
  output logic                  inB_ack,
  input  logic                  inC_req,
  input  logic [data_width-1:0] inC_data,
  output logic                  inC_ack,
  input  logic                  inD_req,
  input  logic [data_width-1:0] inD_data,
  output logic                  inD_ack,
  output logic                  out_req,
  output logic [data_width-1:0] out_data,
  input  logic                  out_ack,
  output logic [3:0]            grant,
  output logic                  locked
);

  sched_state_t          state, next_state;
  chan_id_t              win_q;
  chan_id_t              last_win;
  logic [NUM_CH-1:0]     req_vec;
  logic [NUM_CH-1:0]     pick_req;
  logic                  pick_found;
  chan_id_t              pick_win;
  logic [data_width-1:0] pick_data;
  logic                  take;
  logic                  rtz_done;
  grant_t                ack_vec;

  assign req_vec = {inD_req, inC_req, inB_req, inA_req};

  // While a packet is in progress only its owner may compete.
  assign pick_req = locked ? (req_vec & grant) : req_vec;

  rr_pick4 u_pick (
    .req      (pick_req),
    .last_win (last_win),
    .found    (pick_found),
    .win      (pick_win)
  );

  // A new grant is only issued from IDLE once the sink has returned its ack to zero.
  assign take     = (state == IDLE) && !out_ack && pick_found;
  assign rtz_done = (state == RTZ) && !out_ack && !req_vec[win_q];

  // Select the winning channel's flit for capture into out_data.
  always_comb begin
    pick_data = inA_data;
    case (pick_win)
      2'd0:    pick_data = inA_data;
      2'd1:    pick_data = inB_data;
      2'd2:    pick_data = inC_data;
      default: pick_data = inD_data;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic for the IDLE -> SEND -> RTZ handshake cycle.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (take)     next_state = SEND;
      SEND:    if (out_ack)  next_state = RTZ;
      RTZ:     if (rtz_done) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Flit capture, ownership, lock flag and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data <= '0;
      grant    <= '0;
      win_q    <= '0;
      locked   <= 1'b0;
      last_win <= chan_id_t'(NUM_CH - 1);
    end else begin
      if (take) begin
        out_data <= pick_data;
        grant    <= to_onehot(pick_win);
        win_q    <= pick_win;
      end
      if (rtz_done) begin
        if (out_data[TAIL_BIT]) begin
          locked   <= 1'b0;
          grant    <= '0;
          last_win <= win_q;
        end else begin
          locked   <= 1'b1;
        end
      end
    end
  end

  // Handshake outputs decoded from the registered state; ack only ever goes to the owner.
  always_comb begin
    out_req = (state == SEND);
    ack_vec = (state == RTZ) ? grant : '0;
  end

  assign inA_ack = ack_vec[0];
  assign inB_ack = ack_vec[1];
  assign inC_ack = ack_vec[2];
  assign inD_ack = ack_vec[3];

endmodule
